// File: rtl/reservation_station.sv
// reservation_station: 8-entry operand wait buffer that sends one ready op per cycle to the ALU.
// Define RS_WAKEUP_BYPASS_EN to let an entry woken by this cycle's broadcast dispatch in the same cycle.
module reservation_station (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_config,
  input  logic        in_config,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_precise,
  input  logic        in_more_precise,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_PC,
  input  logic [3:0]  in_rob_entry,
  input  logic        in_qj_busy,
  input  logic [3:0]  in_qj,
  input  logic [31:0] in_vj,
  input  logic        in_qk_busy,
  input  logic [3:0]  in_qk,
  input  logic [31:0] in_vk,
  input  logic        alu_config,
  input  logic [3:0]  alu_rob_entry,
  input  logic [31:0] alu_val,
  input  logic        lsb_config,
  input  logic [3:0]  lsb_rob_entry,
  input  logic [31:0] lsb_val,
  output logic        out_config,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_PC,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_precise,
  output logic        out_more_precise,
  output logic [31:0] out_imm,
  output logic [3:0]  out_rob_entry,
  output logic        out_full
);

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned PREC_W  = 3;
  localparam int unsigned FULL_AT = 7;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   opcode;
    logic [PREC_W-1:0] precise;
    logic              more_precise;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [TAG_W-1:0]  rob_entry;
    logic              qj_busy;
    logic [TAG_W-1:0]  qj;
    logic [XLEN-1:0]   vj;
    logic              qk_busy;
    logic [TAG_W-1:0]  qk;
    logic [XLEN-1:0]   vk;
  } entry_t;

  entry_t             rs_q [ENTRIES];
  entry_t             rs_d [ENTRIES];
  entry_t             woke [ENTRIES];
  entry_t             new_entry;
  entry_t             disp_entry;
  logic [ENTRIES-1:0] ready;
  logic               free_found;
  logic               disp_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   disp_idx;
  logic [CNT_W-1:0]   occupancy;

  // Apply this cycle's broadcasts to waiting operands; ALU wins over LSB on equal tags.
  always_comb begin : wakeup_ready
    for (int i = 0; i < ENTRIES; i++) begin
      woke[i] = rs_q[i];
      if (rs_q[i].busy && rs_q[i].qj_busy) begin
        if (alu_config && rs_q[i].qj == alu_rob_entry) begin
          woke[i].qj_busy = 1'b0;
          woke[i].vj      = alu_val;
        end else if (lsb_config && rs_q[i].qj == lsb_rob_entry) begin
          woke[i].qj_busy = 1'b0;
          woke[i].vj      = lsb_val;
        end
      end
      if (rs_q[i].busy && rs_q[i].qk_busy) begin
        if (alu_config && rs_q[i].qk == alu_rob_entry) begin
          woke[i].qk_busy = 1'b0;
          woke[i].vk      = alu_val;
        end else if (lsb_config && rs_q[i].qk == lsb_rob_entry) begin
          woke[i].qk_busy = 1'b0;
          woke[i].vk      = lsb_val;
        end
      end
`ifdef RS_WAKEUP_BYPASS_EN
      ready[i] = woke[i].busy && !woke[i].qj_busy && !woke[i].qk_busy;
`else
      ready[i] = rs_q[i].busy && !rs_q[i].qj_busy && !rs_q[i].qk_busy;
`endif
    end
  end

  // Incoming op, capturing any operand broadcast in the same cycle.
  always_comb begin : issue_capture
    new_entry              = '0;
    new_entry.busy         = 1'b1;
    new_entry.opcode       = in_opcode;
    new_entry.precise      = in_precise;
    new_entry.more_precise = in_more_precise;
    new_entry.imm          = in_imm;
    new_entry.pc           = in_PC;
    new_entry.rob_entry    = in_rob_entry;
    new_entry.qj_busy      = in_qj_busy;
    new_entry.qj           = in_qj;
    new_entry.vj           = in_vj;
    new_entry.qk_busy      = in_qk_busy;
    new_entry.qk           = in_qk;
    new_entry.vk           = in_vk;
    if (in_qj_busy) begin
      if (alu_config && in_qj == alu_rob_entry) begin
        new_entry.qj_busy = 1'b0;
        new_entry.vj      = alu_val;
      end else if (lsb_config && in_qj == lsb_rob_entry) begin
        new_entry.qj_busy = 1'b0;
        new_entry.vj      = lsb_val;
      end
    end
    if (in_qk_busy) begin
      if (alu_config && in_qk == alu_rob_entry) begin
        new_entry.qk_busy = 1'b0;
        new_entry.vk      = alu_val;
      end else if (lsb_config && in_qk == lsb_rob_entry) begin
        new_entry.qk_busy = 1'b0;
        new_entry.vk      = lsb_val;
      end
    end
  end

  // Lowest free slot, lowest ready slot and occupancy, all from pre-dispatch state.
  always_comb begin : select
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    occupancy  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!rs_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i] && !disp_found) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      occupancy = occupancy + CNT_W'(rs_q[i].busy);
    end
    disp_entry = woke[disp_idx];
  end

  always_comb begin : next_state
    for (int i = 0; i < ENTRIES; i++) begin
      rs_d[i] = woke[i];
    end
    if (disp_found) begin
      rs_d[disp_idx].busy = 1'b0;
    end
    if (in_config && free_found) begin
      rs_d[free_idx] = new_entry;
    end
  end

  assign out_full = (occupancy >= CNT_W'(FULL_AT));

  // Reset and rollback both empty the table and zero the ALU port.
  always_ff @(posedge clk) begin : regs
    if (rst || rollback_config) begin
      for (int i = 0; i < ENTRIES; i++) begin
        rs_q[i] <= '0;
      end
      out_config       <= 1'b0;
      out_a            <= '0;
      out_b            <= '0;
      out_PC           <= '0;
      out_opcode       <= '0;
      out_precise      <= '0;
      out_more_precise <= 1'b0;
      out_imm          <= '0;
      out_rob_entry    <= '0;
    end else if (rdy) begin
      for (int i = 0; i < ENTRIES; i++) begin
        rs_q[i] <= rs_d[i];
      end
      out_config <= disp_found;
      if (disp_found) begin
        out_a            <= disp_entry.vj;
        out_b            <= disp_entry.vk;
        out_PC           <= disp_entry.pc;
        out_opcode       <= disp_entry.opcode;
        out_precise      <= disp_entry.precise;
        out_more_precise <= disp_entry.more_precise;
        out_imm          <= disp_entry.imm;
        out_rob_entry    <= disp_entry.rob_entry;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed issues push expected dispatches, a monitor pops them.
module tb_reservation_station;

`ifdef RS_WAKEUP_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, rollback_config;
  logic        in_config, in_more_precise, in_qj_busy, in_qk_busy;
  logic [6:0]  in_opcode;
  logic [2:0]  in_precise;
  logic [31:0] in_imm, in_PC, in_vj, in_vk;
  logic [3:0]  in_rob_entry, in_qj, in_qk;
  logic        alu_config, lsb_config;
  logic [3:0]  alu_rob_entry, lsb_rob_entry;
  logic [31:0] alu_val, lsb_val;
  logic        out_config, out_more_precise, out_full;
  logic [31:0] out_a, out_b, out_PC, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_precise;
  logic [3:0]  out_rob_entry;

  typedef struct {
    logic [31:0] a, b, pc, imm;
    logic [6:0]  op;
    logic [3:0]  rob;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   e, b;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_config(rollback_config),
    .in_config(in_config), .in_opcode(in_opcode), .in_precise(in_precise),
    .in_more_precise(in_more_precise), .in_imm(in_imm), .in_PC(in_PC),
    .in_rob_entry(in_rob_entry), .in_qj_busy(in_qj_busy), .in_qj(in_qj), .in_vj(in_vj),
    .in_qk_busy(in_qk_busy), .in_qk(in_qk), .in_vk(in_vk),
    .alu_config(alu_config), .alu_rob_entry(alu_rob_entry), .alu_val(alu_val),
    .lsb_config(lsb_config), .lsb_rob_entry(lsb_rob_entry), .lsb_val(lsb_val),
    .out_config(out_config), .out_a(out_a), .out_b(out_b), .out_PC(out_PC),
    .out_opcode(out_opcode), .out_precise(out_precise), .out_more_precise(out_more_precise),
    .out_imm(out_imm), .out_rob_entry(out_rob_entry), .out_full(out_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; single-cycle pulses drop back to idle afterwards.
  task automatic step();
    @(negedge clk);
    in_config = 1'b0; alu_config = 1'b0; lsb_config = 1'b0; rollback_config = 1'b0;
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] rob, input logic qjb, input logic [3:0] qj,
                             input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                             input logic [31:0] vk);
    in_config = 1'b1; in_opcode = op; in_imm = imm; in_PC = pc; in_rob_entry = rob;
    in_precise = rob[2:0]; in_more_precise = rob[0];
    in_qj_busy = qjb; in_qj = qj; in_vj = vj; in_qk_busy = qkb; in_qk = qk; in_vk = vk;
  endtask

  task automatic expect_disp(input logic [31:0] a, input logic [31:0] bv, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [6:0] op, input logic [3:0] rob,
                             input int at);
    exp_t x;
    x.a = a; x.b = bv; x.pc = pc; x.imm = imm; x.op = op; x.rob = rob; x.cyc = at;
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && out_config === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dispatch: rob=%0d pc=0x%0h at cycle %0d, none expected",
                   out_rob_entry, out_PC, cyc);
        end else begin
          x = sbq.pop_front();
          chk($sformatf("disp_cycle rob%0d", x.rob), 32'(cyc), 32'(x.cyc));
          chk($sformatf("out_a rob%0d", x.rob), out_a, x.a);
          chk($sformatf("out_b rob%0d", x.rob), out_b, x.b);
          chk($sformatf("out_PC rob%0d", x.rob), out_PC, x.pc);
          chk($sformatf("out_imm rob%0d", x.rob), out_imm, x.imm);
          chk($sformatf("out_opcode rob%0d", x.rob), 32'(out_opcode), 32'(x.op));
          chk($sformatf("out_rob_entry rob%0d", x.rob), 32'(out_rob_entry), 32'(x.rob));
          chk($sformatf("out_precise rob%0d", x.rob), 32'(out_precise), 32'(x.rob[2:0]));
          chk($sformatf("out_more_precise rob%0d", x.rob), 32'(out_more_precise), 32'(x.rob[0]));
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; rdy = 1'b1; rollback_config = 1'b0;
    in_config = 1'b0; in_opcode = '0; in_precise = '0; in_more_precise = 1'b0;
    in_imm = '0; in_PC = '0; in_rob_entry = '0; in_qj_busy = 1'b0; in_qj = '0; in_vj = '0;
    in_qk_busy = 1'b0; in_qk = '0; in_vk = '0;
    alu_config = 1'b0; alu_rob_entry = '0; alu_val = '0;
    lsb_config = 1'b0; lsb_rob_entry = '0; lsb_val = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_out_config", 32'(out_config), 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_rob_entry", 32'(out_rob_entry), 0);
    chk("rst_out_full", 32'(out_full), 0);

    // Independent ADDI dispatches on the edge after issue, then outputs hold.
    e = cyc + 1;
    drive_issue(7'h13, 32'd3, 32'h100, 4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
    expect_disp(32'd5, 32'd0, 32'h100, 32'd3, 7'h13, 4'd2, e + 1);
    repeat (3) step();
    chk("idle_out_config", 32'(out_config), 0);
    chk("hold_out_a", out_a, 32'd5);
    chk("hold_out_rob_entry", 32'(out_rob_entry), 32'd2);

    // ADD waiting on tag 4, woken by ALU two cycles after issue.
    e = cyc + 1;
    drive_issue(7'h33, 32'd0, 32'h104, 4'd5, 1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd7);
    step();
    step();
    alu_config = 1'b1; alu_rob_entry = 4'd4; alu_val = 32'd10;
    b = cyc + 1;
    expect_disp(32'd10, 32'd7, 32'h104, 32'd0, 7'h33, 4'd5, b + 1 - BYP);
    repeat (4) step();

    // Same-cycle LSB capture at issue.
    e = cyc + 1;
    drive_issue(7'h33, 32'd0, 32'h108, 4'd7, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'h11);
    lsb_config = 1'b1; lsb_rob_entry = 4'd6; lsb_val = 32'h55;
    expect_disp(32'h55, 32'h11, 32'h108, 32'd0, 7'h33, 4'd7, e + 1);
    repeat (3) step();

    // Same-cycle capture with both broadcasters on one tag: ALU value wins.
    e = cyc + 1;
    drive_issue(7'h33, 32'd0, 32'h10c, 4'd1, 1'b1, 4'd3, 32'd0, 1'b1, 4'd3, 32'd0);
    alu_config = 1'b1; alu_rob_entry = 4'd3; alu_val = 32'hAA;
    lsb_config = 1'b1; lsb_rob_entry = 4'd3; lsb_val = 32'hBB;
    expect_disp(32'hAA, 32'hAA, 32'h10c, 32'd0, 7'h33, 4'd1, e + 1);
    repeat (3) step();

    // Entries 1 and 3 woken together: lowest index goes first.
    drive_issue(7'h33, 32'd0, 32'h200, 4'd8,  1'b1, 4'd8,  32'd0, 1'b0, 4'd0, 32'h20); step();
    drive_issue(7'h31, 32'd0, 32'h204, 4'd9,  1'b1, 4'd9,  32'd0, 1'b0, 4'd0, 32'h21); step();
    drive_issue(7'h33, 32'd0, 32'h208, 4'd10, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'h22); step();
    drive_issue(7'h35, 32'd0, 32'h20c, 4'd11, 1'b1, 4'd9,  32'd0, 1'b0, 4'd0, 32'h23); step();
    alu_config = 1'b1; alu_rob_entry = 4'd9; alu_val = 32'h99;
    b = cyc + 1;
    expect_disp(32'h99, 32'h21, 32'h204, 32'd0, 7'h31, 4'd9,  b + 1 - BYP);
    expect_disp(32'h99, 32'h23, 32'h20c, 32'd0, 7'h35, 4'd11, b + 2 - BYP);
    repeat (4) step();
    alu_config = 1'b1; alu_rob_entry = 4'd8;  alu_val = 32'h88;
    lsb_config = 1'b1; lsb_rob_entry = 4'd10; lsb_val = 32'hA0;
    b = cyc + 1;
    expect_disp(32'h88, 32'h20, 32'h200, 32'd0, 7'h33, 4'd8,  b + 1 - BYP);
    expect_disp(32'hA0, 32'h22, 32'h208, 32'd0, 7'h33, 4'd10, b + 2 - BYP);
    repeat (4) step();

    // Fill the table with ops blocked on tag 15.
    for (int i = 0; i < 8; i++) begin
      drive_issue(7'h33, 32'(i), 32'h300 + 32'(4 * i), 4'(i), 1'b1, 4'd15, 32'd0,
                  1'b0, 4'd0, 32'h40 + 32'(i));
      step();
      if (i == 5) chk("full_at_6", 32'(out_full), 0);
      if (i == 6) chk("full_at_7", 32'(out_full), 1);
    end
    chk("full_at_8", 32'(out_full), 1);
    $display("PROTOCOL: issue at cycle %0d presented while all entries busy; must be dropped", cyc + 1);
    drive_issue(7'h13, 32'd0, 32'h3ff, 4'd12, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0);
    step();
    chk("full_after_drop", 32'(out_full), 1);

    // Broadcasts while stalled must be ignored.
    rdy = 1'b0;
    repeat (2) begin
      alu_config = 1'b1; alu_rob_entry = 4'd15; alu_val = 32'hF0;
      step();
    end
    rdy = 1'b1;
    step();
    chk("stall_full", 32'(out_full), 1);
    chk("stall_out_config", 32'(out_config), 0);

    alu_config = 1'b1; alu_rob_entry = 4'd15; alu_val = 32'hF0;
    b = cyc + 1;
    for (int i = 0; i < 8; i++)
      expect_disp(32'hF0, 32'h40 + 32'(i), 32'h300 + 32'(4 * i), 32'(i), 7'h33, 4'(i), b + 1 - BYP + i);
    repeat (11) step();
    chk("drained_full", 32'(out_full), 0);

    // Rollback with rdy low empties the table and zeroes the outputs.
    for (int i = 0; i < 5; i++) begin
      drive_issue(7'h33, 32'd0, 32'h500 + 32'(4 * i), 4'(i), 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
    end
    e = cyc + 1;
    drive_issue(7'h13, 32'd5, 32'h520, 4'd13, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h67);
    expect_disp(32'h66, 32'h67, 32'h520, 32'd5, 7'h13, 4'd13, e + 1);
    step();
    step();
    chk("pre_rollback_out_config", 32'(out_config), 1);
    rollback_config = 1'b1; rdy = 1'b0;
    step();
    rdy = 1'b1;
    chk("rb_out_config", 32'(out_config), 0);
    chk("rb_out_a", out_a, 0);
    chk("rb_out_PC", out_PC, 0);
    chk("rb_out_rob_entry", 32'(out_rob_entry), 0);
    chk("rb_out_full", 32'(out_full), 0);
    alu_config = 1'b1; alu_rob_entry = 4'd14; alu_val = 32'h1;
    repeat (3) step();

    e = cyc + 1;
    drive_issue(7'h13, 32'd1, 32'h600, 4'd3, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'hA);
    expect_disp(32'h9, 32'hA, 32'h600, 32'd1, 7'h13, 4'd3, e + 1);
    repeat (3) step();
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
